// File: rtl/nn_pkg.sv
// rtl/nn_pkg.sv - shared constants and types for the mine/rock classifier sequencer
package nn_pkg;

    localparam int N_ZNACAJKI = 60;
    localparam int W          = 16;
    localparam int N_SKRIVENI = 5;
    localparam int N_IZLAZ    = 2;

    typedef enum logic [1:0] {
        ST_LOAD   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_HOLD   = 2'd2
    } stanje_t;

    typedef logic signed [W-1:0] znacajka_t;

endpackage

// File: rtl/nn_sekvencer_if.sv
// rtl/nn_sekvencer_if.sv - feature input stream and result output stream of the sequencer
interface nn_sekvencer_if #(
    parameter int W = 16
);
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_znacajka;
    logic         in_last;

    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_izlaz_1;
    logic [W-1:0] out_izlaz_2;
    logic         out_mina;

    // Feature producer / result consumer side
    modport master (
        output in_valid, in_znacajka, in_last, out_ready,
        input  in_ready, out_valid, out_izlaz_1, out_izlaz_2, out_mina
    );

    // Sequencer side
    modport slave (
        input  in_valid, in_znacajka, in_last, out_ready,
        output in_ready, out_valid, out_izlaz_1, out_izlaz_2, out_mina
    );
endinterface

// File: rtl/nn_uzorak_spremnik.sv
// rtl/nn_uzorak_spremnik.sv - indexed sample register with feature counter and frame check
module nn_uzorak_spremnik #(
    parameter int N_ZNACAJKI = 60,
    parameter int W          = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    beat,
    input  logic [W-1:0]            znacajka,
    input  logic                    last,
    output logic [N_ZNACAJKI*W-1:0] uzorak,
    output logic                    okvir_ok,
    output logic                    okvir_greska
);
    import nn_pkg::*;

    localparam int            KW       = $clog2(N_ZNACAJKI);
    localparam logic [KW-1:0] K_ZADNJI = KW'(N_ZNACAJKI - 1);

    logic [KW-1:0]           k_q, k_d;
    logic [N_ZNACAJKI*W-1:0] uzorak_q, uzorak_d;
    logic                    zadnji;

    // A frame is good only when in_last coincides exactly with the final index
    assign zadnji       = (k_q == K_ZADNJI);
    assign okvir_ok     = beat & zadnji & last;
    assign okvir_greska = beat & (zadnji ^ last);
    assign uzorak       = uzorak_q;

    // Write the accepted feature at slot k; restart the count at any frame end (good or bad)
    always_comb begin
        uzorak_d = uzorak_q;
        k_d      = k_q;
        if (beat) begin
            uzorak_d[int'(k_q)*W +: W] = znacajka;
            if (okvir_ok || okvir_greska) begin
                k_d = '0;
            end else begin
                k_d = k_q + 1'b1;
            end
        end
    end

    // Sample and counter registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            uzorak_q <= '0;
            k_q      <= '0;
        end else begin
            uzorak_q <= uzorak_d;
            k_q      <= k_d;
        end
    end

endmodule

// File: rtl/nn_sekvencer.sv
// rtl/nn_sekvencer.sv - load / settle / hold sequencer around the combinational classifier
module nn_sekvencer #(
    parameter int N_ZNACAJKI = 60,
    parameter int W          = 16,
    parameter int SETTLE     = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    nn_sekvencer_if.slave           bus,
    output logic [N_ZNACAJKI*W-1:0] uzorak,
    input  logic [W-1:0]            izlaz_1,
    input  logic [W-1:0]            izlaz_2,
    output logic                    greska,
    input  logic                    clear_greska
);
    import nn_pkg::*;

    localparam logic [7:0] CNT_ZADNJI = 8'(SETTLE - 1);

    stanje_t      state_q, state_d;
    logic [7:0]   cnt_q, cnt_d;
    logic [W-1:0] izlaz_1_q, izlaz_1_d;
    logic [W-1:0] izlaz_2_q, izlaz_2_d;
    logic         mina_q, mina_d;
    logic         greska_q, greska_d;
    logic         in_ready_q, in_ready_d;
    logic         out_valid_q, out_valid_d;

    logic         beat;
    logic         okvir_ok;
    logic         okvir_greska;

    // in_ready is only ever high in LOAD, so it alone gates acceptance
    assign beat = bus.in_valid & in_ready_q;

    nn_uzorak_spremnik #(
        .N_ZNACAJKI (N_ZNACAJKI),
        .W          (W)
    ) u_spremnik (
        .clk          (clk),
        .rst_n        (rst_n),
        .beat         (beat),
        .znacajka     (bus.in_znacajka),
        .last         (bus.in_last),
        .uzorak       (uzorak),
        .okvir_ok     (okvir_ok),
        .okvir_greska (okvir_greska)
    );

    // Next state, settle count, result capture and sticky error (set beats clear)
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        izlaz_1_d = izlaz_1_q;
        izlaz_2_d = izlaz_2_q;
        mina_d    = mina_q;
        greska_d  = greska_q;

        case (state_q)
            ST_LOAD: begin
                if (okvir_ok) begin
                    state_d = ST_SETTLE;
                    cnt_d   = '0;
                end
            end
            ST_SETTLE: begin
                cnt_d = cnt_q + 8'd1;
                if (cnt_q == CNT_ZADNJI) begin
                    izlaz_1_d = izlaz_1;
                    izlaz_2_d = izlaz_2;
                    mina_d    = ($signed(izlaz_1) > $signed(izlaz_2));
                    state_d   = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (out_valid_q && bus.out_ready) begin
                    state_d = ST_LOAD;
                end
            end
            default: begin
                state_d = ST_LOAD;
            end
        endcase

        if (okvir_greska) begin
            greska_d = 1'b1;
        end else if (clear_greska) begin
            greska_d = 1'b0;
        end

        in_ready_d  = (state_d == ST_LOAD);
        out_valid_d = (state_d == ST_HOLD);
    end

    // FSM and output registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_LOAD;
            cnt_q       <= '0;
            izlaz_1_q   <= '0;
            izlaz_2_q   <= '0;
            mina_q      <= 1'b0;
            greska_q    <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            izlaz_1_q   <= izlaz_1_d;
            izlaz_2_q   <= izlaz_2_d;
            mina_q      <= mina_d;
            greska_q    <= greska_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.in_ready    = in_ready_q;
    assign bus.out_valid   = out_valid_q;
    assign bus.out_izlaz_1 = izlaz_1_q;
    assign bus.out_izlaz_2 = izlaz_2_q;
    assign bus.out_mina    = mina_q;
    assign greska          = greska_q;

endmodule
